// File: rtl/noc_vc_input_buffer.sv
// NoC router input-port buffer: per-VC circular FIFOs with a round-robin,
// packet-locked drain that masks the switch allocator for a whole wormhole packet.
module noc_vc_input_buffer #(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 8,
    parameter int NUM_VC    = 2,
    parameter int PKT_FLITS = 5,
    localparam int VC_W     = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [VC_W-1:0]   push_vc_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [NUM_VC-1:0] full_o,
    output logic [NUM_VC-1:0] empty_o,
    output logic              overflow_o,
    output logic              req_o,
    input  logic              grant_i,
    input  logic              pop_req_i,
    output logic [DATA_W-1:0] data_o,
    output logic [VC_W-1:0]   vc_o,
    output logic              valid_o,
    output logic              mask_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int FC_W  = (PKT_FLITS > 1) ? $clog2(PKT_FLITS + 1) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [NUM_VC][DEPTH];
    logic [PTR_W-1:0]  wr_ptr [NUM_VC];
    logic [PTR_W-1:0]  rd_ptr [NUM_VC];
    logic [CNT_W-1:0]  count  [NUM_VC];
    logic [VC_W-1:0]   rr_ptr;
    logic [VC_W-1:0]   lock_vc;
    logic [VC_W-1:0]   sel_vc;
    logic [VC_W-1:0]   pop_vc;
    logic [FC_W-1:0]   flit_cnt;
    logic [NUM_VC-1:0] push_hit;
    logic [NUM_VC-1:0] pop_hit;
    logic              vc_ok;
    logic              push_ok;
    logic              push_bad;
    logic              pop_en;
    logic              pkt_last;

    function automatic logic [VC_W-1:0] next_vc(input logic [VC_W-1:0] v);
        next_vc = (int'(v) >= NUM_VC - 1) ? {VC_W{1'b0}} : v + VC_W'(1'b1);
    endfunction

    // Per-VC status flags derived from the registered occupancy counts.
    always_comb begin
        full_o  = {NUM_VC{1'b0}};
        empty_o = {NUM_VC{1'b0}};
        for (int v = 0; v < NUM_VC; v++) begin
            full_o[v]  = (count[v] == CNT_W'(DEPTH));
            empty_o[v] = (count[v] == {CNT_W{1'b0}});
        end
    end

    assign req_o  = (state == IDLE) && (|(~empty_o));
    assign mask_o = (state == SEND);

    // Round-robin pick: iterate backwards so the first non-empty VC at/after rr_ptr wins.
    always_comb begin
        sel_vc = rr_ptr;
        for (int i = NUM_VC - 1; i >= 0; i--) begin
            int idx;
            idx    = int'(rr_ptr) + i;
            idx    = (idx >= NUM_VC) ? idx - NUM_VC : idx;
            sel_vc = empty_o[idx] ? sel_vc : VC_W'(idx);
        end
    end

    // Push acceptance, pop decision and the per-VC hit vectors that update counts.
    always_comb begin
        vc_ok    = (int'(push_vc_i) < NUM_VC);
        push_ok  = push_i && vc_ok && !full_o[push_vc_i];
        push_bad = push_i && !push_ok;
        pop_en   = 1'b0;
        pop_vc   = sel_vc;
        pkt_last = 1'b0;
        case (state)
            IDLE: begin
                pop_en   = grant_i && pop_req_i && req_o;
                pop_vc   = sel_vc;
                pkt_last = (PKT_FLITS == 1);
            end
            SEND: begin
                pop_en   = pop_req_i && !empty_o[lock_vc];
                pop_vc   = lock_vc;
                pkt_last = (flit_cnt == FC_W'(PKT_FLITS - 1));
            end
            default: begin
                pop_en   = 1'b0;
                pop_vc   = sel_vc;
                pkt_last = 1'b0;
            end
        endcase
        push_hit = {NUM_VC{1'b0}};
        pop_hit  = {NUM_VC{1'b0}};
        for (int v = 0; v < NUM_VC; v++) begin
            push_hit[v] = push_ok && (push_vc_i == VC_W'(v));
            pop_hit[v]  = pop_en && (pop_vc == VC_W'(v));
        end
    end

    // Flit storage; contents need no reset because pointers/counts define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[push_vc_i][wr_ptr[push_vc_i]] <= data_i;
        end
    end

    // Pointers, counts, output register and packet-lock FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < NUM_VC; v++) begin
                wr_ptr[v] <= {PTR_W{1'b0}};
                rd_ptr[v] <= {PTR_W{1'b0}};
                count[v]  <= {CNT_W{1'b0}};
            end
            state      <= IDLE;
            rr_ptr     <= {VC_W{1'b0}};
            lock_vc    <= {VC_W{1'b0}};
            flit_cnt   <= {FC_W{1'b0}};
            overflow_o <= 1'b0;
            valid_o    <= 1'b0;
            data_o     <= {DATA_W{1'b0}};
            vc_o       <= {VC_W{1'b0}};
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (push_hit[v]) begin
                    wr_ptr[v] <= wr_ptr[v] + PTR_W'(1'b1);
                end
                if (pop_hit[v]) begin
                    rd_ptr[v] <= rd_ptr[v] + PTR_W'(1'b1);
                end
                case ({push_hit[v], pop_hit[v]})
                    2'b10:   count[v] <= count[v] + CNT_W'(1'b1);
                    2'b01:   count[v] <= count[v] - CNT_W'(1'b1);
                    default: count[v] <= count[v];
                endcase
            end
            overflow_o <= overflow_o | push_bad;
            valid_o    <= pop_en;
            if (pop_en) begin
                data_o <= mem[pop_vc][rd_ptr[pop_vc]];
                vc_o   <= pop_vc;
            end
            case (state)
                IDLE: begin
                    if (pop_en) begin
                        lock_vc <= sel_vc;
                        if (pkt_last) begin
                            rr_ptr   <= next_vc(sel_vc);
                            flit_cnt <= {FC_W{1'b0}};
                        end else begin
                            state    <= SEND;
                            flit_cnt <= FC_W'(1'b1);
                        end
                    end
                end
                SEND: begin
                    if (pop_en) begin
                        if (pkt_last) begin
                            state    <= IDLE;
                            rr_ptr   <= next_vc(lock_vc);
                            flit_cnt <= {FC_W{1'b0}};
                        end else begin
                            flit_cnt <= flit_cnt + FC_W'(1'b1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_vc_input_buffer.sv
// Directed bench for noc_vc_input_buffer (default parameters: 16-bit, DEPTH 8, 2 VCs, 5-flit packets).
module tb_noc_vc_input_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        push_i;
    logic [0:0]  push_vc_i;
    logic [15:0] data_i;
    logic [1:0]  full_o;
    logic [1:0]  empty_o;
    logic        overflow_o;
    logic        req_o;
    logic        grant_i;
    logic        pop_req_i;
    logic [15:0] data_o;
    logic [0:0]  vc_o;
    logic        valid_o;
    logic        mask_o;

    int n_assert = 0;
    int n_fail   = 0;

    noc_vc_input_buffer dut (
        .clk(clk), .rst(rst), .push_i(push_i), .push_vc_i(push_vc_i), .data_i(data_i),
        .full_o(full_o), .empty_o(empty_o), .overflow_o(overflow_o), .req_o(req_o),
        .grant_i(grant_i), .pop_req_i(pop_req_i), .data_o(data_o), .vc_o(vc_o),
        .valid_o(valid_o), .mask_o(mask_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic out(input string tag, input logic v, input logic [15:0] d,
                       input logic c, input logic m);
        check({tag, ".valid"}, 32'(valid_o), 32'(v));
        if (v) begin
            check({tag, ".data"}, 32'(data_o), 32'(d));
            check({tag, ".vc"}, 32'(vc_o), 32'(c));
        end
        check({tag, ".mask"}, 32'(mask_o), 32'(m));
    endtask

    task automatic push(input logic c, input logic [15:0] d);
        push_i = 1'b1; push_vc_i = c; data_i = d;
        tick();
        push_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; push_i = 1'b0; push_vc_i = 1'b0; data_i = 16'h0000;
        grant_i = 1'b0; pop_req_i = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst.data", 32'(data_o), 32'h0);
        check("rst.vc", 32'(vc_o), 32'h0);
        check("rst.valid", 32'(valid_o), 32'h0);
        check("rst.mask", 32'(mask_o), 32'h0);
        check("rst.ovf", 32'(overflow_o), 32'h0);
        check("rst.req", 32'(req_o), 32'h0);
        check("rst.full", 32'(full_o), 32'h0);
        check("rst.empty", 32'(empty_o), 32'h3);

        // Single packet on VC0
        push(1'b0, 16'h0001);
        check("t1.empty_first", 32'(empty_o), 32'h2);
        check("t1.req_first", 32'(req_o), 32'h1);
        for (int k = 2; k <= 5; k++) push(1'b0, 16'(k));
        grant_i = 1'b1; pop_req_i = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            out("t1.pop", 1'b1, 16'(k), 1'b0, (k != 5));
        end
        grant_i = 1'b0; pop_req_i = 1'b0;
        tick();
        out("t1.idle", 1'b0, 16'h0, 1'b0, 1'b0);
        check("t1.req_empty", 32'(req_o), 32'h0);
        check("t1.empty_end", 32'(empty_o), 32'h3);

        // Two packets; rr_ptr is now 1 so VC1 drains first, then VC0
        for (int k = 1; k <= 5; k++) push(1'b0, 16'(16'h0010 + k));
        for (int k = 1; k <= 5; k++) push(1'b1, 16'(16'h0020 + k));
        grant_i = 1'b1; pop_req_i = 1'b1;
        for (int j = 0; j < 10; j++) begin
            tick();
            out("t2.pop", 1'b1, (j < 5) ? 16'(16'h0021 + j) : 16'(16'h0011 + j - 5),
                (j < 5), ((j % 5) != 4));
        end
        tick();
        out("t2.empty_grant", 1'b0, 16'h0, 1'b0, 1'b0);
        check("t2.req", 32'(req_o), 32'h0);
        grant_i = 1'b0; pop_req_i = 1'b0;

        // Mid-packet stall on VC0 (rr_ptr=1, VC1 empty)
        for (int k = 1; k <= 5; k++) push(1'b0, 16'(16'h0030 + k));
        grant_i = 1'b1; pop_req_i = 1'b1;
        tick(); out("t3.f1", 1'b1, 16'h0031, 1'b0, 1'b1);
        tick(); out("t3.f2", 1'b1, 16'h0032, 1'b0, 1'b1);
        pop_req_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            out("t3.stall", 1'b0, 16'h0, 1'b0, 1'b1);
            check("t3.hold", 32'(data_o), 32'h0032);
        end
        pop_req_i = 1'b1;
        for (int k = 3; k <= 5; k++) begin
            tick();
            out("t3.resume", 1'b1, 16'(16'h0030 + k), 1'b0, (k != 5));
        end
        grant_i = 1'b0; pop_req_i = 1'b0;

        // Mid-packet underflow on VC1 (rr_ptr=1)
        for (int k = 1; k <= 3; k++) push(1'b1, 16'(16'h0040 + k));
        grant_i = 1'b1; pop_req_i = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            out("t4.pop", 1'b1, 16'(16'h0040 + k), 1'b1, 1'b1);
        end
        push_i = 1'b1; push_vc_i = 1'b1; data_i = 16'h0044;
        tick();
        out("t4.underflow", 1'b0, 16'h0, 1'b0, 1'b1);
        data_i = 16'h0045;
        tick();
        out("t4.f4", 1'b1, 16'h0044, 1'b1, 1'b1);
        push_i = 1'b0;
        tick();
        out("t4.f5", 1'b1, 16'h0045, 1'b1, 1'b0);
        grant_i = 1'b0; pop_req_i = 1'b0;
        tick();
        out("t4.idle", 1'b0, 16'h0, 1'b0, 1'b0);

        // Fill VC1, overflow on the 9th push
        for (int k = 1; k <= 7; k++) push(1'b1, 16'(16'h0050 + k));
        check("t5.full7", 32'(full_o), 32'h0);
        push(1'b1, 16'h0058);
        check("t5.full8", 32'(full_o), 32'h2);
        check("t5.ovf8", 32'(overflow_o), 32'h0);
        push(1'b1, 16'h0059);
        check("t5.ovf9", 32'(overflow_o), 32'h1);
        check("t5.full9", 32'(full_o), 32'h2);
        tick();
        check("t5.ovf_sticky", 32'(overflow_o), 32'h1);
        // Pop with push while full: push rejected
        grant_i = 1'b1; pop_req_i = 1'b1;
        push_i = 1'b1; push_vc_i = 1'b1; data_i = 16'h005A;
        tick();
        out("t5.pop_full", 1'b1, 16'h0051, 1'b1, 1'b1);
        check("t5.full_after_pop", 32'(full_o), 32'h0);
        // Pop with push at count 7: count unchanged
        data_i = 16'h005B;
        tick();
        out("t5.pop_push", 1'b1, 16'h0052, 1'b1, 1'b1);
        check("t5.full_pp", 32'(full_o), 32'h0);
        pop_req_i = 1'b0; data_i = 16'h005C;
        tick();
        push_i = 1'b0;
        check("t5.refull", 32'(full_o), 32'h2);
        out("t5.nopop", 1'b0, 16'h0, 1'b0, 1'b1);
        pop_req_i = 1'b1;
        tick(); out("t5.f3", 1'b1, 16'h0053, 1'b1, 1'b1);
        tick(); out("t5.f4", 1'b1, 16'h0054, 1'b1, 1'b1);
        tick(); out("t5.f5", 1'b1, 16'h0055, 1'b1, 1'b0);

        // Next packet from VC1 (rr wraps to 0, VC0 empty); reset at flit 3
        tick(); out("t6.f1", 1'b1, 16'h0056, 1'b1, 1'b1);
        tick(); out("t6.f2", 1'b1, 16'h0057, 1'b1, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0; grant_i = 1'b0; pop_req_i = 1'b0;
        check("t6.data", 32'(data_o), 32'h0);
        check("t6.vc", 32'(vc_o), 32'h0);
        check("t6.valid", 32'(valid_o), 32'h0);
        check("t6.mask", 32'(mask_o), 32'h0);
        check("t6.ovf", 32'(overflow_o), 32'h0);
        check("t6.req", 32'(req_o), 32'h0);
        check("t6.full", 32'(full_o), 32'h0);
        check("t6.empty", 32'(empty_o), 32'h3);
        tick();
        check("t6.empty_after", 32'(empty_o), 32'h3);
        check("t6.req_after", 32'(req_o), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
